core_rst_seq: RTL and testbench
===============================

# core_rst_seq

Per-core reset sequencer for the multi-core subsystem. It owns every core's active-low reset line: it holds all cores in reset after system reset, then releases a configured boot set in staggered order. Afterwards it executes software reset commands (assert, release, pulse), enforcing a minimum reset-hold time and an inter-release gap. It sits behind the core-info register block, whose SET_RST/CLR_RST writes are translated into commands on this block's command port, and it scales the single rst_n_1 output to N cores.

## Interface
Parameters:
- N_CORES, 2, number of managed cores (1..16)
- CORE_ID_WIDTH, 4, width of cmd_core
- HOLD_CYCLES, 16, minimum cycles a core reset stays asserted (>=1)
- STAGGER_CYCLES, 8, gap cycles after any release before the next action (>=1)
- AUTO_RELEASE_MASK, 'b1, N_CORES-bit set of cores released automatically after system reset

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_op  in  2  0=ASSERT, 1=RELEASE, 2=PULSE, 3=reserved
- cmd_core  in  CORE_ID_WIDTH  target core index
- cmd_err  out  1  one-cycle pulse: the accepted command was invalid
- core_rst_n  out  N_CORES  per-core reset, active-low, registered
- busy  out  1  sequencer not in IDLE

## Operation
- Reset values: core_rst_n=0 (all cores held), cmd_err=0, state=BOOT_HOLD, busy=1, cmd_ready=0.
- Reset also sets: cnt=HOLD_CYCLES-1, pending=AUTO_RELEASE_MASK.
- The down-counter cnt is sized for max(HOLD_CYCLES, STAGGER_CYCLES).
- In every timed state: if cnt!=0, decrement cnt; if cnt==0, the state expires at that edge.
- BOOT_HOLD, on expiry:
  - pending==0 -> IDLE.
  - Otherwise release the lowest-index pending core, clear its pending bit, cnt<=STAGGER_CYCLES-1, go to BOOT_GAP.
- BOOT_GAP, on expiry:
  - pending==0 -> IDLE.
  - Otherwise release the next lowest pending core, clear its bit, reload cnt, stay in BOOT_GAP.
- IDLE: cmd_ready=1. On an accepted command:
  - cmd_core>=N_CORES or cmd_op==3: cmd_err<=1, no other change, stay in IDLE.
  - ASSERT: core_rst_n[c]<=0, cnt<=HOLD_CYCLES-1, go to HOLD(op=ASSERT). This also applies to a core already held and re-arms the minimum hold.
  - RELEASE, core held: core_rst_n[c]<=1, cnt<=STAGGER_CYCLES-1, go to GAP.
  - RELEASE, core already released: no-op, stay in IDLE, no error.
  - PULSE: core_rst_n[c]<=0, cnt<=HOLD_CYCLES-1, go to HOLD(op=PULSE).
- HOLD, on expiry:
  - op=ASSERT -> IDLE; the core stays in reset.
  - op=PULSE -> core_rst_n[c]<=1, cnt<=STAGGER_CYCLES-1, go to GAP.
- GAP, on expiry -> IDLE.
- Outputs: cmd_ready=(state==IDLE); busy=(state!=IDLE).
- Target core and op are latched at accept. Outputs for other cores never change during a command.

## Timing
- Accept at edge T:
  - core_rst_n changes at T+1.
  - cmd_err, if raised, is high for cycle T+1 only.
  - cmd_ready is low from T+1 unless the command leaves the state in IDLE (error or no-op RELEASE), so back-to-back accepts are legal in those cases.
- ASSERT: core low from T+1; cmd_ready high again at T+1+HOLD_CYCLES.
- PULSE: core low for exactly HOLD_CYCLES cycles (T+1..T+HOLD_CYCLES), high at T+1+HOLD_CYCLES; cmd_ready at T+1+HOLD_CYCLES+STAGGER_CYCLES.
- RELEASE of a held core: high at T+1; cmd_ready at T+1+STAGGER_CYCLES.
- Boot, with R = first cycle with rst_n=1:
  - k-th released core (k=0,1,...) goes high at R+HOLD_CYCLES+k*STAGGER_CYCLES.
  - IDLE at R+HOLD_CYCLES+popcount(mask)*STAGGER_CYCLES.
- rst_n low at any edge, in any state: all core_rst_n=0 at the next cycle, the in-flight command is discarded, and boot restarts.
- cmd_valid while cmd_ready=0 is ignored. The requester holds it; nothing is queued.

## Test plan
- Default boot (mask 'b01, HOLD=16, STAGGER=8, N=2) -> core_rst_n[0] rises at R+16; core 1 stays 0; cmd_ready rises at R+24.
- Boot with mask 'b11 -> core0 high at R+16, core1 high at R+24, busy falls and cmd_ready rises at R+32.
- PULSE core 0 accepted at T -> core_rst_n[0]=0 over T+1..T+16, 1 at T+17; cmd_ready at T+25; core1 unchanged.
- ASSERT core 1 at T, then RELEASE core 1 as soon as cmd_ready returns (T+17) -> core1 high at T+18; cmd_ready at T+26. RELEASE of an already-released core -> accepted with no gap; next command accepted the following cycle.
- cmd_core=5 with N=2, and separately cmd_op=3 -> cmd_err=1 for one cycle, core_rst_n unchanged, cmd_ready stays 1.
- rst_n pulled low at T+5 during a PULSE of core 0 -> all core_rst_n=0; boot timing restarts from the new R, matching the first scenario.

Source files
------------

// File: rtl/core_rst_seq.sv
// Per-core reset sequencer: holds all cores after system reset, releases a boot
// set in staggered order, then serves assert/release/pulse commands.
module core_rst_seq #(
  parameter int N_CORES = 2,
  parameter int CORE_ID_WIDTH = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter logic [N_CORES-1:0] AUTO_RELEASE_MASK = 'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CORE_ID_WIDTH-1:0] cmd_core,
  output logic                     cmd_err,
  output logic [N_CORES-1:0]       core_rst_n,
  output logic                     busy
);

  localparam int MAXC = (HOLD_CYCLES > STAGGER_CYCLES) ?
                        HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LD = CW'(STAGGER_CYCLES - 1);
  localparam logic [CORE_ID_WIDTH:0] NC =
    N_CORES[CORE_ID_WIDTH:0];

  localparam logic [1:0] OP_ASSERT  = 2'd0;
  localparam logic [1:0] OP_RELEASE = 2'd1;
  localparam logic [1:0] OP_PULSE   = 2'd2;

  typedef enum logic [2:0] {
    BOOT_HOLD,
    BOOT_GAP,
    IDLE,
    HOLD,
    GAP
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [N_CORES-1:0] pending;
  logic [N_CORES-1:0] rst_q;
  logic [IW-1:0]      tgt;
  logic               op_pulse;
  logic               err_q;

  logic               expired;
  logic               bad_cmd;
  logic [IW-1:0]      cidx;
  logic [IW-1:0]      nxt_idx;

  assign expired = (cnt == '0);
  assign bad_cmd = ({1'b0, cmd_core} >= NC) || (cmd_op == 2'd3);
  assign cidx    = cmd_core[IW-1:0];

  // lowest-index pending core for the boot release order
  always_comb begin
    nxt_idx = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (pending[i]) nxt_idx = IW'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state    <= BOOT_HOLD;
      cnt      <= HOLD_LD;
      pending  <= AUTO_RELEASE_MASK;
      rst_q    <= '0;
      tgt      <= '0;
      op_pulse <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state != IDLE && !expired) cnt <= cnt - 1'b1;
      unique case (state)
        BOOT_HOLD, BOOT_GAP: begin
          if (expired) begin
            if (pending == '0) begin
              state <= IDLE;
            end else begin
              rst_q[nxt_idx]   <= 1'b1;
              pending[nxt_idx] <= 1'b0;
              cnt              <= STAG_LD;
              state            <= BOOT_GAP;
            end
          end
        end
        IDLE: begin
          if (cmd_valid) begin
            if (bad_cmd) begin
              err_q <= 1'b1;
            end else begin
              tgt      <= cidx;
              op_pulse <= (cmd_op == OP_PULSE);
              unique case (1'b1)
                cmd_op == OP_ASSERT,
                cmd_op == OP_PULSE: begin
                  rst_q[cidx] <= 1'b0;
                  cnt         <= HOLD_LD;
                  state       <= HOLD;
                end
                cmd_op == OP_RELEASE: begin
                  if (!rst_q[cidx]) begin
                    rst_q[cidx] <= 1'b1;
                    cnt         <= STAG_LD;
                    state       <= GAP;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        HOLD: begin
          if (expired) begin
            if (op_pulse) begin
              rst_q[tgt] <= 1'b1;
              cnt        <= STAG_LD;
              state      <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (expired) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign core_rst_n = rst_q;
  assign cmd_err    = err_q;
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_core_rst_seq.sv
// Directed bench for core_rst_seq: boot timing for two masks, command table,
// pulse/assert/release timing and reset during a command.
module tb_core_rst_seq;

  logic       clk_i = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_valid2;
  logic [1:0] cmd_op;
  logic [3:0] cmd_core;

  logic       cmd_ready, cmd_err, busy;
  logic [1:0] core_rst_n;
  logic       ready2, err2, busy2;
  logic [1:0] core2;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  core_rst_seq dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_core(cmd_core),
    .cmd_err(cmd_err), .core_rst_n(core_rst_n), .busy(busy)
  );

  core_rst_seq #(.AUTO_RELEASE_MASK(2'b11)) dut2 (
    .clk_i(clk_i), .rst_n(rst_n),
    .cmd_valid(cmd_valid2), .cmd_ready(ready2),
    .cmd_op(cmd_op), .cmd_core(cmd_core),
    .cmd_err(err2), .core_rst_n(core2), .busy(busy2)
  );

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [3:0] core;
    logic [1:0] e_rst;
    logic       e_rdy;
    logic       e_err;
    logic       e_busy;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic wait_ready(input string nm, input int exp_n);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    chk(nm, n, exp_n);
  endtask

  // called at a negedge while rst_n is low; this cycle becomes R
  task automatic boot_check(input string tag);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 15) begin
        chk({tag, "_c15"}, core_rst_n, 2'b00);
        chk({tag, "_d2c15"}, core2, 2'b00);
      end
      if (k == 16) begin
        chk({tag, "_c16"}, core_rst_n, 2'b01);
        chk({tag, "_d2c16"}, core2, 2'b01);
      end
      if (k == 23) begin
        chk({tag, "_rdy23"}, cmd_ready, 1'b0);
        chk({tag, "_d2c23"}, core2, 2'b01);
      end
      if (k == 24) begin
        chk({tag, "_rdy24"}, cmd_ready, 1'b1);
        chk({tag, "_busy24"}, busy, 1'b0);
        chk({tag, "_c24"}, core_rst_n, 2'b01);
        chk({tag, "_d2c24"}, core2, 2'b11);
        chk({tag, "_d2rdy24"}, ready2, 1'b0);
      end
      if (k == 31) chk({tag, "_d2rdy31"}, ready2, 1'b0);
      if (k == 32) begin
        chk({tag, "_d2rdy32"}, ready2, 1'b1);
        chk({tag, "_d2busy32"}, busy2, 1'b0);
      end
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'd0, 4'd5,  2'b01, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 2'd3, 4'd0,  2'b01, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 2'd1, 4'd0,  2'b01, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 2'd0, 4'd0,  2'b01, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 2'd1, 4'd0,  2'b01, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 2'd2, 4'd15, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 2'd1, 4'd1,  2'b11, 1'b0, 1'b0, 1'b1};

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_valid2 = 1'b0;
    cmd_op     = 2'd0;
    cmd_core   = 4'd0;
    step();
    step();
    step();
    chk("rst_core", core_rst_n, 2'b00);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_err", cmd_err, 1'b0);
    chk("rst_d2core", core2, 2'b00);

    boot_check("boot");

    for (int i = 0; i < 7; i++) begin
      cmd_valid = tbl[i].v;
      cmd_op    = tbl[i].op;
      cmd_core  = tbl[i].core;
      step();
      chk($sformatf("vec%0d_rst", i), core_rst_n, tbl[i].e_rst);
      chk($sformatf("vec%0d_rdy", i), cmd_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_err", i), cmd_err, tbl[i].e_err);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
    end
    cmd_valid = 1'b0;
    wait_ready("rel1_gap", 8);
    chk("rel1_err_clr", cmd_err, 1'b0);

    // PULSE core 0
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_core  = 4'd0;
    step();
    cmd_valid = 1'b0;
    chk("pulse_t1", core_rst_n, 2'b10);
    chk("pulse_t1_rdy", cmd_ready, 1'b0);
    for (int k = 2; k <= 16; k++) begin
      step();
      if (k == 16) chk("pulse_t16", core_rst_n, 2'b10);
    end
    step();
    chk("pulse_t17", core_rst_n, 2'b11);
    chk("pulse_t17_rdy", cmd_ready, 1'b0);
    wait_ready("pulse_gap", 8);

    // ASSERT core 1, RELEASE held by requester during the hold
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_core  = 4'd1;
    step();
    chk("assert_t1", core_rst_n, 2'b01);
    chk("assert_t1_rdy", cmd_ready, 1'b0);
    cmd_op = 2'd1;
    wait_ready("assert_hold", 16);
    chk("assert_t17_core", core_rst_n, 2'b01);
    step();
    cmd_valid = 1'b0;
    chk("release_t18", core_rst_n, 2'b11);
    chk("release_t18_rdy", cmd_ready, 1'b0);
    wait_ready("release_gap", 8);

    // system reset in the middle of a PULSE
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_core  = 4'd0;
    step();
    cmd_valid = 1'b0;
    for (int k = 2; k <= 5; k++) step();
    chk("mid_t5", core_rst_n, 2'b10);
    rst_n = 1'b0;
    step();
    chk("mid_rst_core", core_rst_n, 2'b00);
    chk("mid_rst_busy", busy, 1'b1);
    chk("mid_rst_rdy", cmd_ready, 1'b0);
    chk("mid_rst_d2", core2, 2'b00);
    step();
    boot_check("reboot");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
